// File: rtl/vma_pkg.sv
// vma_pkg: burst FSM state encoding, burst-length width and a saturating increment.
// Shared by vma_mem and vma. Build option of vma_mem: VMA_MEM_STATS_EN.
package vma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } burst_state_e;

    localparam int BURST_LEN_W = 16;

    // Increment that sticks at all-ones so very long bursts never wrap
    function automatic logic [BURST_LEN_W-1:0] sat_inc(input logic [BURST_LEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vma_mem_if.sv
// vma_mem_if: bundle of the vma_mem request/response bus.
// The master drives requests; the slave (memory) drives read data, error and burst status.
interface vma_mem_if
    import vma_pkg::*;
();
    logic                   write_en;
    logic [31:0]            write_data;
    logic                   read_en;
    logic [31:0]            read_data;
    logic [31:0]            memaddr;
    logic                   err;
    logic                   err_clr;
    logic                   burst_done;
    logic                   burst_wr;
    logic [BURST_LEN_W-1:0] burst_len;

    modport master (
        output write_en, write_data, read_en, memaddr, err_clr,
        input  read_data, err, burst_done, burst_wr, burst_len
    );

    modport slave (
        input  write_en, write_data, read_en, memaddr, err_clr,
        output read_data, err, burst_done, burst_wr, burst_len
    );
endinterface

// File: rtl/vma_mem_wbuf.sv
// vma_mem_wbuf: word array plus a one-entry write buffer.
// A loaded write sits in the buffer for one cycle and is committed on the next edge;
// reads of the buffered word are forwarded from the buffer so they never see stale data.
module vma_mem_wbuf #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [IDX_W-1:0] i_load_idx,
    input  logic [31:0]      i_load_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data
);

    logic [31:0]      r_mem [DEPTH];
    logic             r_wb_valid;
    logic [IDX_W-1:0] r_wb_idx;
    logic [31:0]      r_wb_data;

    // Capture each valid write; a reset drops any entry that has not been committed yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= i_load;
            if (i_load) begin
                r_wb_idx  <= i_load_idx;
                r_wb_data <= i_load_data;
            end
        end
    end

    // Commit the buffered word one edge after capture; array contents are not reset
    always_ff @(posedge clk) begin
        if (r_wb_valid) begin
            r_mem[r_wb_idx] <= r_wb_data;
        end
    end

    assign o_rd_data = (r_wb_valid && (r_wb_idx == i_rd_idx)) ? r_wb_data : r_mem[i_rd_idx];

endmodule

// File: rtl/vma_mem.sv
// vma_mem: word memory with address decode, sticky error flag and burst tracking.
// Optional build macro VMA_MEM_STATS_EN adds o_rd_beats/o_wr_beats valid-beat counters.
module vma_mem
    import vma_pkg::*;
#(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_write_en,
    input  logic [31:0]            i_write_data,
    input  logic                   i_read_en,
    output logic [31:0]            o_read_data,
    input  logic [31:0]            i_memaddr,
    output logic                   o_err,
    input  logic                   i_err_clr,
    output logic                   o_burst_done,
    output logic                   o_burst_wr,
    output logic [BURST_LEN_W-1:0] o_burst_len
`ifdef VMA_MEM_STATS_EN
    ,
    output logic [31:0]            o_rd_beats,
    output logic [31:0]            o_wr_beats
`endif
);

    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    logic [32:0]            w_off;
    logic                   w_addr_ok;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_any_req;
    logic                   w_err_set;
    logic                   w_wb_load;
    logic                   w_rd_ok;
    logic [31:0]            w_arr_data;

    burst_state_e           r_state;
    burst_state_e           w_state_next;
    logic                   w_close;
    logic [BURST_LEN_W-1:0] w_beats_next;
    logic [BURST_LEN_W-1:0] r_beats;
    logic                   r_burst_done;
    logic                   r_burst_wr;
    logic [BURST_LEN_W-1:0] r_burst_len;
    logic                   r_err;

    // The extra top bit of the offset is the borrow, flagging addresses below BASE
    assign w_off     = {1'b0, i_memaddr} - {1'b0, BASE};
    assign w_addr_ok = (i_memaddr[1:0] == 2'b00) && !w_off[32] && (w_off < SPAN);
    assign w_idx     = w_off[IDX_W+1:2];
    assign w_any_req = i_write_en | i_read_en;
    assign w_err_set = (w_any_req && !w_addr_ok) || (i_write_en && i_read_en);
    // A simultaneous-enable cycle still performs the write but yields no read data
    assign w_wb_load = i_write_en && w_addr_ok;
    assign w_rd_ok   = i_read_en && !i_write_en && w_addr_ok;

    vma_mem_wbuf #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_wb_load),
        .i_load_idx  (w_idx),
        .i_load_data (i_write_data),
        .i_rd_idx    (w_idx),
        .o_rd_data   (w_arr_data)
    );

    assign o_read_data = (w_rd_ok && rst_n) ? w_arr_data : 32'h0;

    // Burst FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state follows this cycle's beat type; write wins when both enables are high
    always_comb begin
        w_state_next = ST_IDLE;
        if (i_write_en) begin
            w_state_next = ST_WR;
        end else if (i_read_en) begin
            w_state_next = ST_RD;
        end
    end

    // Burst close on any departure from an active state; new or switched bursts start at beat 1
    always_comb begin
        w_close      = (r_state != ST_IDLE) && (w_state_next != r_state);
        w_beats_next = '0;
        if (w_any_req) begin
            w_beats_next = (w_state_next == r_state) ? sat_inc(r_beats) : BURST_LEN_W'(1);
        end
    end

    // Beat counter and registered burst report; length and type hold until the next close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats      <= '0;
            r_burst_done <= 1'b0;
            r_burst_wr   <= 1'b0;
            r_burst_len  <= '0;
        end else begin
            r_beats      <= w_beats_next;
            r_burst_done <= w_close;
            if (w_close) begin
                r_burst_len <= r_beats;
                r_burst_wr  <= (r_state == ST_WR);
            end
        end
    end

    // Sticky error; a new error in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_err        = r_err;
    assign o_burst_done = r_burst_done;
    assign o_burst_wr   = r_burst_wr;
    assign o_burst_len  = r_burst_len;

`ifdef VMA_MEM_STATS_EN
    logic [31:0] r_rd_beats;
    logic [31:0] r_wr_beats;

    // Valid-beat statistics, wrapping naturally and cleared together with the error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_beats <= '0;
            r_wr_beats <= '0;
        end else if (i_err_clr) begin
            r_rd_beats <= '0;
            r_wr_beats <= '0;
        end else begin
            if (w_rd_ok) begin
                r_rd_beats <= r_rd_beats + 32'd1;
            end
            if (w_wb_load) begin
                r_wr_beats <= r_wr_beats + 32'd1;
            end
        end
    end

    assign o_rd_beats = r_rd_beats;
    assign o_wr_beats = r_wr_beats;
`endif

endmodule

// File: tb/tb_vma_mem.sv
// tb_vma_mem: directed-vector bench for vma_mem with hand-computed expectations.
// Builds with or without VMA_MEM_STATS_EN.
module tb_vma_mem;
    import vma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rd_obs;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    vma_mem_if u_if ();

`ifdef VMA_MEM_STATS_EN
    logic [31:0] rd_beats;
    logic [31:0] wr_beats;
`endif

    vma_mem dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_write_en   (u_if.write_en),
        .i_write_data (u_if.write_data),
        .i_read_en    (u_if.read_en),
        .o_read_data  (u_if.read_data),
        .i_memaddr    (u_if.memaddr),
        .o_err        (u_if.err),
        .i_err_clr    (u_if.err_clr),
        .o_burst_done (u_if.burst_done),
        .o_burst_wr   (u_if.burst_wr),
        .o_burst_len  (u_if.burst_len)
`ifdef VMA_MEM_STATS_EN
        ,
        .o_rd_beats   (rd_beats),
        .o_wr_beats   (wr_beats)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive at negedge, sample read data before the edge, status after it
    task automatic cyc(input logic we, input logic re, input logic clr,
                       input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        u_if.write_en   = we;
        u_if.read_en    = re;
        u_if.err_clr    = clr;
        u_if.memaddr    = addr;
        u_if.write_data = data;
        #1;
        rd_obs = u_if.read_data;
        @(posedge clk);
        #1;
        $display("cyc we=%0d re=%0d clr=%0d addr=%h wd=%h rd=%h err=%0d done=%0d len=%0d wr=%0d",
                 we, re, clr, addr, data, rd_obs, u_if.err, u_if.burst_done,
                 u_if.burst_len, u_if.burst_wr);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        cyc(1'b1, 1'b0, 1'b0, addr, data);
    endtask

    task automatic rd(input logic [31:0] addr);
        cyc(1'b0, 1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic idle(input logic clr);
        cyc(1'b0, 1'b0, clr, 32'h0, 32'h0);
    endtask

    task automatic check_done(input string tag, input logic [15:0] len, input logic w);
        check_val({tag, "_done"}, 32'(u_if.burst_done), 32'd1);
        check_val({tag, "_len"},  32'(u_if.burst_len),  32'(len));
        check_val({tag, "_wr"},   32'(u_if.burst_wr),   32'(w));
    endtask

    initial begin
        rst_n           = 1'b0;
        u_if.write_en   = 1'b0;
        u_if.read_en    = 1'b0;
        u_if.err_clr    = 1'b0;
        u_if.memaddr    = 32'h0;
        u_if.write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_err",  32'(u_if.err),        32'd0);
        check_val("rst_done", 32'(u_if.burst_done), 32'd0);
        check_val("rst_len",  32'(u_if.burst_len),  32'd0);
        check_val("rst_wr",   32'(u_if.burst_wr),   32'd0);
        check_val("rst_rd",   u_if.read_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four-word write burst then four-word read burst
        wr(32'h100, 32'h11);
        check_val("b4_w1_done", 32'(u_if.burst_done), 32'd0);
        wr(32'h104, 32'h22);
        wr(32'h108, 32'h33);
        wr(32'h10C, 32'h44);
        rd(32'h100);
        check_val("b4_rd0", rd_obs, 32'h11);
        check_done("b4_wclose", 16'd4, 1'b1);
        rd(32'h104);
        check_val("b4_rd1", rd_obs, 32'h22);
        check_val("b4_pulse1", 32'(u_if.burst_done), 32'd0);
        check_val("b4_hold_len", 32'(u_if.burst_len), 32'd4);
        rd(32'h108);
        check_val("b4_rd2", rd_obs, 32'h33);
        rd(32'h10C);
        check_val("b4_rd3", rd_obs, 32'h44);
        idle(1'b0);
        check_val("idle_rd0", rd_obs, 32'h0);
        check_done("b4_rclose", 16'd4, 1'b0);
        idle(1'b0);
        check_val("b4_idle_done", 32'(u_if.burst_done), 32'd0);
        check_val("b4_idle_len",  32'(u_if.burst_len),  32'd4);

        // Read right after write is forwarded from the buffer
        wr(32'h20, 32'hDEADBEEF);
        rd(32'h20);
        check_val("fwd_rd", rd_obs, 32'hDEADBEEF);
        check_done("fwd_wclose", 16'd1, 1'b1);
        idle(1'b0);
        check_done("fwd_rclose", 16'd1, 1'b0);

        // Misaligned and out-of-range accesses
        rd(32'h2);
        check_val("mis_rd", rd_obs, 32'h0);
        check_val("mis_err", 32'(u_if.err), 32'd1);
        idle(1'b1);
        check_val("clr_err", 32'(u_if.err), 32'd0);
        check_done("mis_close", 16'd1, 1'b0);
        rd(32'h1000);
        check_val("oor_rd", rd_obs, 32'h0);
        check_val("oor_err", 32'(u_if.err), 32'd1);
        idle(1'b0);
        check_val("sticky_err", 32'(u_if.err), 32'd1);
        wr(32'h22, 32'h1234);
        check_val("badwr_err", 32'(u_if.err), 32'd1);
        idle(1'b1);
        check_val("clr2_err", 32'(u_if.err), 32'd0);
        check_done("badwr_close", 16'd1, 1'b1);
        rd(32'h20);
        check_val("badwr_dropped", rd_obs, 32'hDEADBEEF);
        cyc(1'b0, 1'b1, 1'b1, 32'h2, 32'h0);
        check_val("setwins_err", 32'(u_if.err), 32'd1);
        idle(1'b1);
        check_val("clr3_err", 32'(u_if.err), 32'd0);

        // Highest valid word
        wr(32'hFFC, 32'hCAFE0001);
        rd(32'hFFC);
        check_val("top_rd", rd_obs, 32'hCAFE0001);
        check_val("top_err", 32'(u_if.err), 32'd0);
        idle(1'b0);

        // Direct WR->RD switch
        wr(32'h200, 32'h1);
        wr(32'h204, 32'h2);
        wr(32'h208, 32'h3);
        rd(32'h200);
        check_val("sw_rd0", rd_obs, 32'h1);
        check_done("sw_wclose", 16'd3, 1'b1);
        rd(32'h208);
        check_val("sw_rd1", rd_obs, 32'h3);
        check_val("sw_pulse", 32'(u_if.burst_done), 32'd0);
        idle(1'b0);
        check_done("sw_rclose", 16'd2, 1'b0);

        // Reset in the middle of a five-write burst
        wr(32'h308, 32'hAAAA);
        idle(1'b0);
        wr(32'h300, 32'h1);
        wr(32'h304, 32'h2);
        wr(32'h308, 32'h3);
        @(negedge clk);
        rst_n         = 1'b0;
        u_if.write_en = 1'b0;
        u_if.read_en  = 1'b1;
        u_if.memaddr  = 32'h300;
        #1;
        check_val("mrst_rd",   u_if.read_data,       32'd0);
        check_val("mrst_done", 32'(u_if.burst_done), 32'd0);
        check_val("mrst_len",  32'(u_if.burst_len),  32'd0);
        check_val("mrst_wr",   32'(u_if.burst_wr),   32'd0);
        check_val("mrst_err",  32'(u_if.err),        32'd0);
        u_if.read_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("mrst_hold_done", 32'(u_if.burst_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        check_val("mrst_nopulse", 32'(u_if.burst_done), 32'd0);
        rd(32'h308);
        check_val("mrst_discard", rd_obs, 32'hAAAA);
        rd(32'h304);
        check_val("mrst_commit", rd_obs, 32'h2);
        idle(1'b0);
        check_done("mrst_restart", 16'd2, 1'b0);

        // Both enables: write happens, read returns zero, error set
        cyc(1'b1, 1'b1, 1'b0, 32'h40, 32'h55);
        check_val("both_rd",  rd_obs, 32'h0);
        check_val("both_err", 32'(u_if.err), 32'd1);
        idle(1'b1);
        check_val("both_clr", 32'(u_if.err), 32'd0);
        check_done("both_close", 16'd1, 1'b1);
        rd(32'h40);
        check_val("both_wrote", rd_obs, 32'h55);
        idle(1'b0);
        check_done("both_rclose", 16'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vma_mem.md
VMA_MEM -- requirements
Module: vma_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port i_write_en  input  1  meaning a word write request this cycle.
REQ-006 SHALL have port i_write_data  input  32  meaning the write word.
REQ-007 SHALL have port i_read_en  input  1  meaning a word read request this cycle.
REQ-008 SHALL have port o_read_data  output  32  meaning read data, valid in the same cycle as i_read_en.
REQ-009 SHALL have port i_memaddr  input  32  meaning the byte address of the request.
REQ-010 SHALL have port o_err  output  1  meaning sticky access error.
REQ-011 SHALL have port i_err_clr  input  1  meaning clear o_err.
REQ-012 SHALL have port o_burst_done  output  1  meaning a one-cycle pulse at the close of a burst.
REQ-013 SHALL have port o_burst_wr  output  1  meaning the closed burst was a write burst.
REQ-014 SHALL have port o_burst_len  output  16  meaning the beat count of the closed burst.

Function
REQ-015 SHALL decode a request as valid when i_memaddr[1:0]==0 and BASE <= i_memaddr < BASE+4*DEPTH; the word index SHALL be (i_memaddr-BASE)>>2.
REQ-016 SHALL capture a valid write into a one-entry write buffer (addr, data, valid) at the clock edge and commit it to the array at the following edge; back-to-back writes SHALL commit one per cycle with no loss.
REQ-017 SHALL return o_read_data combinationally: the write-buffer data if the buffer is valid and addresses match, otherwise the array word; invalid or idle reads SHALL return 32'h0.
REQ-018 SHALL, on an invalid request, drop the write, return 0 for the read and set o_err at the next edge.
REQ-019 SHALL, when i_write_en and i_read_en are both asserted, perform the write, return 0 read data and set o_err.
REQ-020 SHALL clear o_err on i_err_clr; when a clear and a new error occur in the same cycle, the set SHALL win.
REQ-021 SHALL run the burst FSM with states IDLE, RD, and WR: IDLE->RD on i_read_en, IDLE->WR on i_write_en; RD/WR hold while the same enable repeats; ->IDLE on a cycle with no enable.
REQ-022 SHALL switch directly RD->WR or WR->RD when the enable type changes, closing the old burst and starting a new one at beat 1.
REQ-023 SHALL count beats, including invalid ones, in a 16-bit counter that saturates at 16'hFFFF.
REQ-024 SHALL, on burst close, register o_burst_done=1 for one cycle with o_burst_len and o_burst_wr set to the closed burst's count and type; o_burst_len and o_burst_wr SHALL hold until the next close.
REQ-025 SHALL treat a simultaneous-enable cycle as a WR beat.

Reset
REQ-026 SHALL, on rst_n low, force the FSM to IDLE, clear the beat counter, write-buffer valid, o_err, o_burst_done, o_burst_wr and o_burst_len to 0, and make o_read_data read 0; array contents SHALL be unspecified.
REQ-027 SHALL discard a pending write-buffer entry when reset is asserted mid-burst, and SHALL NOT pulse o_burst_done for that burst.

Configuration
REQ-028 SHALL, when VMA_MEM_STATS_EN is defined, add outputs o_rd_beats[31:0] and o_wr_beats[31:0] counting valid read and write beats; both SHALL wrap modulo 2^32, reset to 0 and clear on i_err_clr.
REQ-029 SHALL, when VMA_MEM_STATS_EN is undefined, omit those ports and counters, with all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE=0, RD=1, WR=2) and the width constant for the burst length in package vma_pkg, which is shared with vma.
REQ-031 SHALL isolate the array and write-buffer forwarding in one sub-module, vma_mem_wbuf; the FSM, decode and error logic SHALL live in vma_mem.

Verification
REQ-032 SHALL cover: write 4 words 0x11..0x44 at 0x100..0x10C, then read 4 -> data 0x11..0x44; done pulses with len=4 wr=1, then len=4 wr=0.
REQ-033 SHALL cover: write 0xDEADBEEF at 0x20, then read 0x20 in the next cycle -> 0xDEADBEEF forwarded from the buffer.
REQ-034 SHALL cover: read at 0x2 and at BASE+4*DEPTH -> 0 returned, o_err=1; i_err_clr -> o_err=0.
REQ-035 SHALL cover: 3 writes immediately followed by 2 reads -> done(len=3, wr=1) at the switch, then done(len=2, wr=0).
REQ-036 SHALL cover: rst_n low in the middle of a 5-write burst -> all outputs 0, no done pulse, FSM IDLE.
REQ-037 SHALL cover: both enables high at 0x40 with data 0x55 -> o_err=1, read 0, later read of 0x40 returns 0x55.
